// File: rtl/fpu_divsqrt_ctrl_if.sv
// Signal bundle between the ID/FPU pipeline and the divide/square-root sequencer.
// The slave modport is the sequencer side; the master modport is the pipeline side.
interface fpu_divsqrt_ctrl_if;
  logic        id_fp;
  logic [2:0]  id_fc;
  logic [4:0]  id_fd;
  logic [4:0]  id_fs;
  logic [4:0]  id_ft;
  logic        id_use_fs;
  logic        id_use_ft;
  logic        id_hold;
  logic        flush;
  logic        e3w;
  logic [31:0] core_result;

  logic        core_start;
  logic        core_sqrt;
  logic        core_abort;
  logic        dsq_w;
  logic [4:0]  dsq_n;
  logic [31:0] dsq_d;
  logic        stall_div_sqrt;
  logic        busy;

  modport slave (
    input  id_fp, id_fc, id_fd, id_fs, id_ft, id_use_fs, id_use_ft, id_hold, flush, e3w,
    input  core_result,
    output core_start, core_sqrt, core_abort, dsq_w, dsq_n, dsq_d, stall_div_sqrt, busy
  );

  modport master (
    output id_fp, id_fc, id_fd, id_fs, id_ft, id_use_fs, id_use_ft, id_hold, flush, e3w,
    output core_result,
    input  core_start, core_sqrt, core_abort, dsq_w, dsq_n, dsq_d, stall_div_sqrt, busy
  );
endinterface

// File: rtl/fpu_divsqrt_ctrl.sv
// Sequencer for the iterative FP divide/sqrt core: accepts one op from ID, counts its fixed
// latency, holds hazarding ID instructions and shares the FP write port with FPU stage E3.
module fpu_divsqrt_ctrl #(
  parameter int unsigned LAT_DIV  = 14,
  parameter int unsigned LAT_SQRT = 10
) (
  input logic                 clk,
  input logic                 rst,
  fpu_divsqrt_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

  // The count loads LAT-1 so that it reaches zero in the final core cycle.
  localparam logic [5:0] CntDiv  = 6'(LAT_DIV - 1);
  localparam logic [5:0] CntSqrt = 6'(LAT_SQRT - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        sqrt_q, sqrt_d;
  logic [31:0] res_q, res_d;

  logic is_ds;
  logic accept;
  logic busy;
  logic first_run;
  logic cnt_done;

  assign is_ds     = bus.id_fp & bus.id_fc[2];
  assign busy      = (state_q != StIdle);
  assign accept    = (state_q == StIdle) & is_ds & ~bus.id_hold & ~bus.flush;
  assign cnt_done  = (cnt_q == 6'd0);
  assign first_run = (state_q == StRun) & (cnt_q == (sqrt_q ? CntSqrt : CntDiv));

  // Structural (any div/sqrt), WAW (same fd) and RAW (source reads rd) hazards.
  // Built only from raw decode so it cannot loop back through wpcir.
  always_comb begin
    bus.stall_div_sqrt = busy & bus.id_fp &
                         (bus.id_fc[2] |
                          (bus.id_fd == rd_q) |
                          (bus.id_use_fs & (bus.id_fs == rd_q)) |
                          (bus.id_use_ft & (bus.id_ft == rd_q)));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      rd_q    <= 5'd0;
      sqrt_q  <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      sqrt_q  <= sqrt_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRun;
      end
      StRun: begin
        if (bus.flush)    state_d = StIdle;
        else if (cnt_done) state_d = StWb;
      end
      StWb: begin
        if (bus.flush || !bus.e3w) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    sqrt_d = sqrt_q;
    res_d  = res_q;
    if (accept) begin
      rd_d   = bus.id_fd;
      sqrt_d = bus.id_fc[1];
      cnt_d  = bus.id_fc[1] ? CntSqrt : CntDiv;
    end else if (state_q == StRun) begin
      if (!cnt_done) cnt_d = cnt_q - 6'd1;
      if (cnt_done && !bus.flush) res_d = bus.core_result;
    end
  end

  // Output logic; everything decodes from registered state so reset clears it at once.
  always_comb begin
    bus.core_start = 1'b0;
    bus.core_sqrt  = 1'b0;
    bus.core_abort = 1'b0;
    bus.dsq_w      = 1'b0;
    bus.dsq_n      = 5'd0;
    bus.dsq_d      = 32'd0;
    bus.busy       = busy;
    unique case (state_q)
      StIdle: ;
      StRun: begin
        bus.core_start = first_run;
        bus.core_sqrt  = sqrt_q;
        bus.core_abort = bus.flush;
      end
      StWb: begin
        bus.dsq_w = ~bus.e3w & ~bus.flush;
        bus.dsq_n = rd_q;
        bus.dsq_d = res_q;
      end
      default: ;
    endcase
  end

  a_single_writer: assert property (@(posedge clk) disable iff (rst) bus.dsq_w |-> !bus.e3w);
  a_no_idle_stall: assert property (@(posedge clk) disable iff (rst)
                                    !bus.busy |-> !bus.stall_div_sqrt);
  a_start_pulse:   assert property (@(posedge clk) disable iff (rst)
                                    bus.core_start |=> !bus.core_start);
  a_abort_idles:   assert property (@(posedge clk) disable iff (rst)
                                    bus.core_abort |=> !bus.busy);

endmodule

// File: tb/tb_fpu_divsqrt_ctrl.sv
// Directed bench for fpu_divsqrt_ctrl: latency, e3w arbitration, hazards, flush, hold, reset.
module tb_fpu_divsqrt_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_divsqrt_ctrl_if bus ();

  fpu_divsqrt_ctrl #(
    .LAT_DIV  (14),
    .LAT_SQRT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Moves to the next cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_id;
    bus.id_fp       = 1'b0;
    bus.id_fc       = 3'b000;
    bus.id_fd       = 5'd0;
    bus.id_fs       = 5'd0;
    bus.id_ft       = 5'd0;
    bus.id_use_fs   = 1'b0;
    bus.id_use_ft   = 1'b0;
    bus.id_hold     = 1'b0;
    bus.flush       = 1'b0;
    bus.e3w         = 1'b0;
    bus.core_result = 32'hdeadbeef;
  endtask

  task automatic set_id(input logic [2:0] fc, input logic [4:0] fd, input logic [4:0] fs,
                        input logic [4:0] ft, input logic ufs, input logic uft);
    bus.id_fp     = 1'b1;
    bus.id_fc     = fc;
    bus.id_fd     = fd;
    bus.id_fs     = fs;
    bus.id_ft     = ft;
    bus.id_use_fs = ufs;
    bus.id_use_ft = uft;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) break;
      tick();
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  logic exp_stall;

  initial begin
    rst = 1'b1;
    clear_id();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_start", {31'd0, bus.core_start}, 32'd0);
    check("rst_abort", {31'd0, bus.core_abort}, 32'd0);
    check("rst_dsq_w", {31'd0, bus.dsq_w}, 32'd0);
    check("rst_dsq_n", {27'd0, bus.dsq_n}, 32'd0);
    check("rst_dsq_d", bus.dsq_d, 32'd0);
    check("rst_stall", {31'd0, bus.stall_div_sqrt}, 32'd0);
    #1 rst = 1'b0;

    // fdiv f3 accepted in cycle 0, e3w low
    tick();
    set_id(3'b100, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
    settle();
    check("div_c0_stall", {31'd0, bus.stall_div_sqrt}, 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      clear_id();
      if (c == 14) bus.core_result = 32'h40400000;
      settle();
      check($sformatf("div_start_c%0d", c), {31'd0, bus.core_start}, {31'd0, c == 1});
      check($sformatf("div_busy_c%0d", c), {31'd0, bus.busy}, {31'd0, c <= 15});
      check($sformatf("div_w_c%0d", c), {31'd0, bus.dsq_w}, {31'd0, c == 15});
      check($sformatf("div_n_c%0d", c), {27'd0, bus.dsq_n}, (c == 15) ? 32'd3 : 32'd0);
      check($sformatf("div_d_c%0d", c), bus.dsq_d, (c == 15) ? 32'h40400000 : 32'd0);
      if (c == 1) check("div_sqrt_sel", {31'd0, bus.core_sqrt}, 32'd0);
    end

    // Hazards against a pending fdiv to f3
    tick();
    set_id(3'b100, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      clear_id();
      exp_stall = 1'b0;
      case (c)
        1: begin set_id(3'b000, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1); exp_stall = 1'b0; end
        2: begin set_id(3'b110, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0); exp_stall = 1'b1; end
        3: begin set_id(3'b010, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1); exp_stall = 1'b1; end
        4: begin set_id(3'b000, 5'd7, 5'd3, 5'd2, 1'b1, 1'b1); exp_stall = 1'b1; end
        5: begin set_id(3'b000, 5'd7, 5'd3, 5'd2, 1'b0, 1'b1); exp_stall = 1'b0; end
        6: begin set_id(3'b000, 5'd7, 5'd1, 5'd3, 1'b1, 1'b1); exp_stall = 1'b1; end
        7: begin set_id(3'b000, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1); bus.id_fp = 1'b0; end
        default: begin
          set_id(3'b000, 5'd7, 5'd3, 5'd2, 1'b1, 1'b1);
          exp_stall = (c <= 15);
        end
      endcase
      settle();
      check($sformatf("haz_stall_c%0d", c), {31'd0, bus.stall_div_sqrt}, {31'd0, exp_stall});
      if (c >= 14) check($sformatf("haz_w_c%0d", c), {31'd0, bus.dsq_w}, {31'd0, c == 15});
    end
    clear_id();

    // fsqrt f5 with e3w high in cycles 11..13
    tick();
    set_id(3'b110, 5'd5, 5'd4, 5'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      tick();
      clear_id();
      if (c == 10) bus.core_result = 32'h3fb504f3;
      if (c >= 11 && c <= 13) bus.e3w = 1'b1;
      settle();
      if (c == 1) begin
        check("sq_start", {31'd0, bus.core_start}, 32'd1);
        check("sq_sel",   {31'd0, bus.core_sqrt}, 32'd1);
      end
      if (c == 10) check("sq_n_c10", {27'd0, bus.dsq_n}, 32'd0);
      if (c >= 10 && c <= 14) begin
        check($sformatf("sq_w_c%0d", c), {31'd0, bus.dsq_w}, {31'd0, c == 14});
        check($sformatf("sq_busy_c%0d", c), {31'd0, bus.busy}, 32'd1);
      end
      if (c >= 11 && c <= 14) begin
        check($sformatf("sq_n_c%0d", c), {27'd0, bus.dsq_n}, 32'd5);
        check($sformatf("sq_d_c%0d", c), bus.dsq_d, 32'h3fb504f3);
      end
      if (c == 15) check("sq_busy_c15", {31'd0, bus.busy}, 32'd0);
    end

    // Flush in cycle 6 of an fdiv, then fsqrt f5 accepted in cycle 7
    tick();
    set_id(3'b100, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      tick();
      clear_id();
      if (c == 6) bus.flush = 1'b1;
      if (c == 7) set_id(3'b110, 5'd5, 5'd4, 5'd0, 1'b1, 1'b0);
      if (c == 17) bus.core_result = 32'h41000000;
      settle();
      check($sformatf("fl_w_c%0d", c), {31'd0, bus.dsq_w}, {31'd0, c == 18});
      if (c == 5) check("fl_abort_c5", {31'd0, bus.core_abort}, 32'd0);
      if (c == 6) check("fl_abort_c6", {31'd0, bus.core_abort}, 32'd1);
      if (c == 7) begin
        check("fl_busy_c7",  {31'd0, bus.busy}, 32'd0);
        check("fl_stall_c7", {31'd0, bus.stall_div_sqrt}, 32'd0);
        check("fl_abort_c7", {31'd0, bus.core_abort}, 32'd0);
      end
      if (c == 8) begin
        check("fl_start_c8", {31'd0, bus.core_start}, 32'd1);
        check("fl_sel_c8",   {31'd0, bus.core_sqrt}, 32'd1);
      end
      if (c == 18) begin
        check("fl_n_c18", {27'd0, bus.dsq_n}, 32'd5);
        check("fl_d_c18", bus.dsq_d, 32'h41000000);
      end
    end
    wait_idle("fl_drain");

    // is_ds blocked by id_hold, then by flush, then accepted
    tick();
    set_id(3'b100, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.id_hold = 1'b1;
    settle();
    check("hold_busy_a", {31'd0, bus.busy}, 32'd0);
    tick();
    settle();
    check("hold_start", {31'd0, bus.core_start}, 32'd0);
    check("hold_busy_b", {31'd0, bus.busy}, 32'd0);
    bus.id_hold = 1'b0;
    bus.flush   = 1'b1;
    tick();
    settle();
    check("flidle_start", {31'd0, bus.core_start}, 32'd0);
    check("flidle_busy",  {31'd0, bus.busy}, 32'd0);
    bus.flush = 1'b0;
    tick();
    clear_id();
    settle();
    check("hold_acc_start", {31'd0, bus.core_start}, 32'd1);
    check("hold_acc_busy",  {31'd0, bus.busy}, 32'd1);
    wait_idle("hold_drain");

    // Reset pulse during WB while e3w blocks the write
    tick();
    set_id(3'b100, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      tick();
      clear_id();
      if (c == 14) bus.core_result = 32'h12345678;
      if (c == 15) bus.e3w = 1'b1;
      settle();
    end
    check("rwb_busy", {31'd0, bus.busy}, 32'd1);
    check("rwb_w",    {31'd0, bus.dsq_w}, 32'd0);
    check("rwb_n",    {27'd0, bus.dsq_n}, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("rwb_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rwb_rst_n",    {27'd0, bus.dsq_n}, 32'd0);
    check("rwb_rst_d",    bus.dsq_d, 32'd0);
    check("rwb_rst_w",    {31'd0, bus.dsq_w}, 32'd0);
    tick();
    rst = 1'b0;
    bus.e3w = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      check($sformatf("rwb_post_w_%0d", c), {31'd0, bus.dsq_w}, 32'd0);
      check($sformatf("rwb_post_busy_%0d", c), {31'd0, bus.busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
